// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states,
// the latched request record and the per-size alignment mask.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Everything the FSM needs after acceptance; the bus may change freely then.
  typedef struct packed {
    logic        write;
    size_e       size;
    logic        is_signed;
    logic        err;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(size_e size);
    case (size)
      SZ_BYTE: return 3'b000;
      SZ_HALF: return 3'b001;
      SZ_WORD: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  // Execute stage drives requests and receives responses.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: extracts/extends load data from a
// doubleword and merges store bytes into a doubleword (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  lane,
  input  size_e       size,
  input  logic        is_signed,
  input  logic [63:0] line,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] line_sh;
  logic [63:0] wdata_sh;
  logic [7:0]  be_base;
  logic [7:0]  be;

  assign shamt    = {lane, 3'b000};
  assign line_sh  = line >> shamt;
  assign wdata_sh = wdata << shamt;

  // Extract the addressed bytes and zero- or sign-extend them.
  always_comb begin
    rdata = line_sh;
    case (size)
      SZ_BYTE: rdata = {{56{is_signed & line_sh[7]}},  line_sh[7:0]};
      SZ_HALF: rdata = {{48{is_signed & line_sh[15]}}, line_sh[15:0]};
      SZ_WORD: rdata = {{32{is_signed & line_sh[31]}}, line_sh[31:0]};
      default: rdata = line_sh;
    endcase
  end

  // Replace the enabled byte lanes of the line with the shifted store data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
    be_base = 8'h01;
    case (size)
      SZ_BYTE: be_base = 8'h01;
      SZ_HALF: be_base = 8'h03;
      SZ_WORD: be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    be     = be_base << lane;
    merged = line;
    for (int k = 0; k < 8; k++) begin
      if (be[k]) merged[8*k +: 8] = wdata_sh[8*k +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed requests, performs doubleword
// reads, read-modify-write stores and full doubleword writes, and returns a
// one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic [63:0] mem_raddr,
  output logic        mem_read_en,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic        mem_write_en,
  output logic [63:0] mem_wdata
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [63:0] line_q, line_d;

  logic        misaligned;
  logic        out_of_range;
  logic [63:0] ext_rdata;
  logic [63:0] merged_line;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  assign misaligned   = |(bus.req_addr[2:0] & align_mask(size_e'(bus.req_size)));
  assign out_of_range = bus.req_addr[63:3] >= 61'(MEM_DEPTH);

  lsu_lane_align u_lane_align (
    .lane      (req_q.addr[2:0]),
    .size      (req_q.size),
    .is_signed (req_q.is_signed),
    .line      (line_q),
    .wdata     (req_q.wdata),
    .rdata     (ext_rdata),
    .merged    (merged_line)
  );

  // Next-state, request capture, line-buffer load and all outputs.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    line_d       = line_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_read_en  = 1'b0;
    mem_raddr    = '0;
    mem_write_en = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d.write     = bus.req_write;
          req_d.size      = size_e'(bus.req_size);
          req_d.is_signed = bus.req_signed;
          req_d.err       = misaligned | out_of_range;
          req_d.addr      = bus.req_addr;
          req_d.wdata     = bus.req_wdata;
          if (misaligned || out_of_range)                          state_d = RESP;
          else if (bus.req_write && size_e'(bus.req_size) == SZ_DWORD) state_d = WRITE;
          else                                                     state_d = READ;
        end
      end
      READ: begin
        mem_read_en = 1'b1;
        mem_raddr   = {3'b000, req_q.addr[63:3]};
        line_d      = mem_rdata;
        state_d     = req_q.write ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        mem_waddr    = {3'b000, req_q.addr[63:3]};
        mem_wdata    = (req_q.size == SZ_DWORD) ? req_q.wdata : merged_line;
        state_d      = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = req_q.err;
        resp_rdata = (!req_q.write && !req_q.err) ? ext_rdata : '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State, request latch and line buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      // NOTE: datapath registers are reset too; they are only a few flops and it keeps outputs deterministic after reset.
      req_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      line_q  <= line_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a vector table applied through a
// request task with a response scoreboard, a behavioural doubleword memory,
// plus a hand-written reset-during-write sequence.
module tb_load_store_unit;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        preload;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en;
  logic [63:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  lsu_if bus ();

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_raddr    (mem_raddr),
    .mem_read_en  (mem_read_en),
    .mem_rdata    (mem_rdata),
    .mem_waddr    (mem_waddr),
    .mem_write_en (mem_write_en),
    .mem_wdata    (mem_wdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on the rising edge.
  assign mem_rdata = (mem_raddr < 64'(DEPTH)) ? mem[mem_raddr[6:0]] : 64'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'h0;
      mem[0] <= 64'h8877665544332211;
    end else if (mem_write_en && mem_waddr < 64'(DEPTH)) begin
      mem[mem_waddr[6:0]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, then follow it to its response and compare.
  task automatic run_req(input vec_t v, input string tag);
    int   w;
    int   lat;
    int   n_rd;
    int   n_wr;
    logic bad_idle;
    logic [63:0] waddr_seen;
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_write  = v.write;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    #1;
    // Scramble the request bus; the DUT must work from its latched copy.
    bus.req_valid  = 1'b0;
    bus.req_write  = ~v.write;
    bus.req_size   = ~v.size;
    bus.req_signed = ~v.sgn;
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};
    lat = 0; n_rd = 0; n_wr = 0; bad_idle = 1'b0; waddr_seen = '1;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read_en) n_rd++;
      if (mem_write_en) begin
        n_wr++;
        waddr_seen = mem_waddr;
      end
      if ((!mem_read_en && mem_raddr != 0) ||
          (!mem_write_en && (mem_waddr != 0 || mem_wdata != 0)) ||
          (!bus.resp_valid && (bus.resp_rdata != 0 || bus.resp_err)))
        bad_idle = 1'b1;
    end while (!bus.resp_valid && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    if (bus.resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      check({tag, "_err"}, 64'(bus.resp_err), 64'(e.err));
    end else begin
      check({tag, "_resp_timeout"}, 64'(bus.resp_valid), 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    check({tag, "_rd_strobes"}, 64'(n_rd),
          64'((!v.exp_err && !(v.write && v.size == 2'd3)) ? 1 : 0));
    check({tag, "_wr_strobes"}, 64'(n_wr), 64'((!v.exp_err && v.write) ? 1 : 0));
    if (!v.exp_err && v.write)
      check({tag, "_waddr"}, waddr_seen, {3'b000, v.addr[63:3]});
    check({tag, "_bus_idle_zero"}, 64'(bad_idle), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
    check({tag, "_rd_en"}, 64'(mem_read_en), 64'd0);
    check({tag, "_wr_en"}, 64'(mem_write_en), 64'd0);
    check({tag, "_raddr"}, mem_raddr, 64'd0);
    check({tag, "_waddr"}, mem_waddr, 64'd0);
    check({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    preload = 1'b1;

    //      wr  sz  sgn  addr     wdata                     exp_rdata                 err lat
    vecs.push_back('{1'b0, 2'd0, 1'b0, 64'h003, 64'h0, 64'h0000000000000044, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h006, 64'h0, 64'hFFFFFFFFFFFF8877, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 64'h006, 64'h0, 64'h0000000000008877, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 64'h007, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h004, 64'h0, 64'h0000000088776655, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h004, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd3, 1'b1, 64'h000, 64'h0, 64'h8877665544332211, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 64'h001, 64'h123456789ABCDEAB, 64'h0, 1'b0, 3});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 64'h001, 64'h0, 64'h00000000000000AB, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h010, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h012, 64'hFFFFFFFFFFFF1234, 64'h0, 1'b0, 3});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h012, 64'h0, 64'h0000000000001234, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h010, 64'h0, 64'h000000001234CDEF, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h002, 64'h0, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h400, 64'h0, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h003, 64'hFFFF, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 64'h3FC, 64'h00000000DEADBEEF, 64'h0, 1'b0, 3});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h3FC, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 64'h3F8, 64'h0, 64'h0, 1'b0, 2});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

    check("mem0_after", mem[0], 64'h887766554433AB11);
    check("mem2_after", mem[2], 64'h012345671234CDEF);
    check("mem127_after", mem[127], 64'hDEADBEEF00000000);

    // Reset asserted during WRITE of a sub-doubleword store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = 64'h0; bus.req_wdata = 64'h11223344;
    check("rstw_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rstw_in_write", 64'(mem_write_en), 64'd1);
    check("rstw_merged", mem_wdata, 64'h8877665511223344);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstw");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_mem0_kept", mem[0], 64'h887766554433AB11);
    check("rstw_no_resp", 64'(bus.resp_valid), 64'd0);
    run_req('{1'b0, 2'd0, 1'b0, 64'h001, 64'h0, 64'h00000000000000AB, 1'b0, 2}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
